// File: rtl/cpu_pkg.sv
// Shared datapath definitions for the CPU: operation codes, the multiply/divide
// state type and the machine word width.
package cpu_pkg;

    localparam int WORD_W = 32;

    localparam logic MULDIV_OP_MUL = 1'b0;
    localparam logic MULDIV_OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } muldiv_state_t;

endpackage

// File: rtl/twos_abs.sv
// Conditional two's-complement negate; with negate tied to the sign bit it
// yields the magnitude of a signed value.
module twos_abs #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/seq_muldiv.sv
// Iterative signed multiply/divide unit writing the Z register pair.
// MUL (radix-2 Booth) and DIV (restoring) share one 65-bit accumulator.
module seq_muldiv
    import cpu_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z_high,
    output logic [WIDTH-1:0] z_low,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    muldiv_state_t state;
    muldiv_state_t next_state;

    logic [CNT_W-1:0] count;
    logic [2*WIDTH:0] acc;
    logic [WIDTH-1:0] m_reg;
    logic             op_reg;
    logic             sign_a;
    logic             sign_b;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] quot_fixed;
    logic [WIDTH-1:0] rem_fixed;

    logic [WIDTH:0]   booth_sum;
    logic [2*WIDTH:0] booth_next;
    logic [WIDTH:0]   div_shifted;
    logic [WIDTH+1:0] div_trial;
    logic [2*WIDTH:0] div_next;

    logic             start_div_zero;

    twos_abs #(.WIDTH(WIDTH)) u_abs_a (
        .value  (operand_a),
        .negate (operand_a[WIDTH-1]),
        .result (mag_a)
    );

    twos_abs #(.WIDTH(WIDTH)) u_abs_b (
        .value  (operand_b),
        .negate (operand_b[WIDTH-1]),
        .result (mag_b)
    );

    twos_abs #(.WIDTH(WIDTH)) u_fix_quot (
        .value  (acc[WIDTH:1]),
        .negate (sign_a ^ sign_b),
        .result (quot_fixed)
    );

    twos_abs #(.WIDTH(WIDTH)) u_fix_rem (
        .value  (acc[2*WIDTH:WIDTH+1]),
        .negate (sign_a),
        .result (rem_fixed)
    );

    assign start_div_zero = (op == MULDIV_OP_DIV) && (operand_b == '0);

    // Booth sum is formed one bit wider so subtracting the most negative
    // multiplicand cannot wrap before the arithmetic shift.
    always_comb begin
        booth_sum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
        case (acc[1:0])
            2'b01:   booth_sum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]} + {m_reg[WIDTH-1], m_reg};
            2'b10:   booth_sum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]} - {m_reg[WIDTH-1], m_reg};
            default: booth_sum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
        endcase
        booth_next = {booth_sum, acc[WIDTH:1]};
    end

    always_comb begin
        div_shifted = {acc[2*WIDTH:WIDTH+1], acc[WIDTH]};
        div_trial   = {1'b0, div_shifted} - {2'b00, m_reg};
        if (!div_trial[WIDTH+1]) begin
            div_next = {div_trial[WIDTH-1:0], acc[WIDTH-1:1], 1'b1, 1'b0};
        end else begin
            div_next = {div_shifted[WIDTH-1:0], acc[WIDTH-1:1], 1'b0, 1'b0};
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = start_div_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (count == '0) begin
                    next_state = FIX;
                end
            end
            FIX:     next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Divide keeps the partial remainder in the upper half and the dividend /
    // quotient in the middle; multiply keeps {A, Q, q-1}.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state       <= IDLE;
            count       <= '0;
            acc         <= '0;
            m_reg       <= '0;
            op_reg      <= MULDIV_OP_MUL;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            z_high      <= '0;
            z_low       <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_reg      <= op;
                        sign_a      <= operand_a[WIDTH-1];
                        sign_b      <= operand_b[WIDTH-1];
                        count       <= CNT_W'(WIDTH - 1);
                        div_by_zero <= start_div_zero;
                        if (op == MULDIV_OP_DIV) begin
                            acc   <= {{WIDTH{1'b0}}, mag_a, 1'b0};
                            m_reg <= mag_b;
                            if (start_div_zero) begin
                                z_high <= operand_a;
                                z_low  <= '1;
                            end
                        end else begin
                            acc   <= {{WIDTH{1'b0}}, operand_b, 1'b0};
                            m_reg <= operand_a;
                        end
                    end
                end
                RUN: begin
                    acc   <= (op_reg == MULDIV_OP_DIV) ? div_next : booth_next;
                    count <= count - CNT_W'(1);
                end
                FIX: begin
                    if (op_reg == MULDIV_OP_DIV) begin
                        z_high <= rem_fixed;
                        z_low  <= quot_fixed;
                    end else begin
                        z_high <= acc[2*WIDTH:WIDTH+1];
                        z_low  <= acc[WIDTH:1];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_seq_muldiv.sv
// Self-checking bench for seq_muldiv: directed cases plus random operations
// compared against a plain-arithmetic reference model.
module tb_seq_muldiv;

    logic        clock;
    logic        clear_n;
    logic        start;
    logic        op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic [31:0] z_high;
    logic [31:0] z_low;
    logic        div_by_zero;

    int checks;
    int failures;

    seq_muldiv #(.WIDTH(32)) dut (
        .clock       (clock),
        .clear_n     (clear_n),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .busy        (busy),
        .done        (done),
        .z_high      (z_high),
        .z_low       (z_low),
        .div_by_zero (div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [64:0] observed, input logic [64:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Returns {div_by_zero, z_high, z_low} from signed arithmetic.
    function automatic logic [64:0] model(input logic op_in, input logic [31:0] a, input logic [31:0] b);
        int     sa;
        int     sb;
        longint prod;
        int     q;
        int     r;
        sa = a;
        sb = b;
        if (op_in == 1'b0) begin
            prod = longint'(sa) * longint'(sb);
            return {1'b0, prod};
        end
        if (b == 32'h0) return {1'b1, a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {1'b0, 32'h0, 32'h80000000};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r, q};
    endfunction

    task automatic applyStimulus(input logic op_in, input logic [31:0] a, input logic [31:0] b,
                                 input int interfere_at);
        logic [64:0] expected;
        int          lat;
        int          busy_cycles;
        int          exp_lat;
        int          exp_busy;
        expected = model(op_in, a, b);
        exp_lat  = (op_in == 1'b1 && b == 32'h0) ? 0 : 33;
        exp_busy = exp_lat + 1;
        @(negedge clock);
        start     = 1'b1;
        op        = op_in;
        operand_a = a;
        operand_b = b;
        @(posedge clock);
        @(negedge clock);
        start     = 1'b0;
        operand_a = $urandom;
        operand_b = $urandom;
        lat         = 0;
        busy_cycles = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cycles++;
            if (lat == interfere_at) begin
                start     = 1'b1;
                op        = $urandom_range(0, 1);
                operand_a = $urandom;
                operand_b = $urandom_range(0, 3);
            end else if (lat == interfere_at + 1) begin
                start = 1'b0;
                op    = op_in;
            end
            @(negedge clock);
            lat++;
        end
        checkOutput("latency", 65'(lat), 65'(exp_lat));
        checkOutput("result", {div_by_zero, z_high, z_low}, expected);
        while (busy && lat < 200) begin
            busy_cycles++;
            @(negedge clock);
            lat++;
        end
        checkOutput("busy_cycles", 65'(busy_cycles), 65'(exp_busy));
        checkOutput("done_low", 65'(done), 65'(0));
    endtask

    initial begin
        logic [31:0] corners [6];
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rop;
        checks    = 0;
        failures  = 0;
        clear_n   = 1'b0;
        start     = 1'b0;
        op        = 1'b0;
        operand_a = '0;
        operand_b = '0;
        corners[0] = 32'h80000000;
        corners[1] = 32'hFFFFFFFF;
        corners[2] = 32'h00000000;
        corners[3] = 32'h7FFFFFFF;
        corners[4] = 32'h00000001;
        corners[5] = 32'hFFFFFFFE;

        repeat (3) @(negedge clock);
        checkOutput("reset_state", {busy, done, div_by_zero, z_high, z_low}, 67'(0));
        clear_n = 1'b1;

        $display("[TB] directed cases");
        applyStimulus(1'b0, 32'd7, 32'hFFFFFFFD, -10);
        applyStimulus(1'b0, 32'h80000000, 32'h80000000, -10);
        repeat (3) @(negedge clock);
        checkOutput("hold", {div_by_zero, z_high, z_low}, {1'b0, 64'h40000000_00000000});
        applyStimulus(1'b1, 32'hFFFFFFF9, 32'd2, -10);
        applyStimulus(1'b1, 32'd7, 32'hFFFFFFFE, -10);
        applyStimulus(1'b1, 32'd5, 32'd0, -10);
        applyStimulus(1'b0, 32'd6, 32'd2, -10);
        applyStimulus(1'b1, 32'h80000000, 32'hFFFFFFFF, -10);
        applyStimulus(1'b0, 32'd1234, 32'hFFFF0000, 10);

        $display("[TB] reset during divide");
        @(negedge clock);
        start     = 1'b1;
        op        = 1'b1;
        operand_a = 32'd1000;
        operand_b = 32'd3;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (14) @(negedge clock);
        clear_n = 1'b0;
        #1;
        checkOutput("reset_mid_op", {busy, done, div_by_zero, z_high, z_low}, 67'(0));
        repeat (3) @(negedge clock);
        clear_n = 1'b1;
        repeat (40) @(negedge clock);
        checkOutput("no_done_after_reset", {busy, done, div_by_zero, z_high, z_low}, 67'(0));
        applyStimulus(1'b1, 32'd100, 32'd7, -10);

        $display("[TB] random cases");
        for (int i = 0; i < 24; i++) begin
            rop = $urandom_range(0, 1);
            ra  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 2) == 0) rb = $urandom_range(1, 40) - 20;
            applyStimulus(rop, ra, rb, -10);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_muldiv.md
# seq_muldiv

Iterative signed multiply/divide unit on the CPU datapath, sitting directly downstream of the bus multiplexer. Operand A is the Y register and operand B is the bus output. Results are written to the Z register pair, which feeds back into the bus multiplexer as the Zhigh and Zlow sources. MUL and DIV share one 32-iteration shift/add engine, which keeps the area small for the datapath.

## Interface
- WIDTH, 32, operand width; the spec is written for 32, result is 2×WIDTH
- clock  in  1  rising-edge clock
- clear_n  in  1  asynchronous, active-low reset
- start  in  1  request pulse; sampled only in IDLE
- op  in  1  0 = MUL, 1 = DIV
- operand_a  in  WIDTH  multiplicand / dividend (from Y)
- operand_b  in  WIDTH  multiplier / divisor (from BusMuxOut)
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse, results valid
- z_high  out  WIDTH  MUL: product[63:32]; DIV: remainder
- z_low  out  WIDTH  MUL: product[31:0]; DIV: quotient
- div_by_zero  out  1  sticky flag from the last operation; cleared on the next accepted start

## Operation
- **States:**
  - IDLE → RUN on start (operands latched, iteration counter = 31).
  - IDLE → DONE on start when op = DIV and operand_b = 0.
  - RUN → FIX when the counter reaches 0 after its iteration.
  - FIX → DONE.
  - DONE → IDLE unconditionally.
- **MUL:** radix-2 Booth, signed × signed. One iteration per RUN cycle on a 65-bit {A, Q, q₋₁} accumulator with arithmetic right shift. The full 64-bit product is exact, so there is no overflow case.
- **DIV:** restoring division on magnitudes, one quotient bit per RUN cycle. FIX applies the signs:
  - the quotient is negated if the operand signs differ (truncation toward zero);
  - the remainder takes the dividend's sign.
- **Divide by zero:** z_low = 32'hFFFFFFFF, z_high = operand_a, div_by_zero = 1.
- **Overflow case:** 0x80000000 / 0xFFFFFFFF gives z_low = 0x80000000, z_high = 0 (wraps, no flag).
- **Output stability:** z_high and z_low are written only on entry to DONE and hold until the next DONE, so the bus sees stable values between operations.
- **start while busy:** ignored; no queuing.
- **Operand changes:** changing operand_a or operand_b after the start edge has no effect.
- **Reset:**
  - clear_n low, at any time including mid-operation: state → IDLE; busy, done, div_by_zero, z_high and z_low → 0.
  - The in-flight operation is discarded.
  - The first start after clear_n rises is accepted normally.

## Timing
- Let k be the edge at which start is sampled in IDLE.
- **Normal operation:**
  - busy rises after edge k.
  - Iterations occur at edges k+1 … k+32.
  - FIX occupies the cycle after edge k+32.
  - Results and done become visible after edge k+33 (latency 33 cycles).
  - done and busy fall after edge k+34.
- **Divide by zero:** results and done become visible after edge k; back in IDLE after edge k+1.
- **Back-to-back:** the earliest next accepted start is the edge k+35 (normal) or k+2 (divide by zero).
- **Outputs:** all outputs are registered; no combinational path from any input to any output.

## Structure
- **Shared cpu_pkg:**
  - MULDIV_OP_MUL / MULDIV_OP_DIV constants.
  - muldiv_state_t enum (IDLE, RUN, FIX, DONE).
  - WORD_W = 32.
- **Sub-module twos_abs:** WIDTH-bit conditional negate / absolute value, instantiated for operand magnitudes and result sign fix.
- **Everything else** lives in one always_ff with the state, counter and accumulator, plus one combinational next-state block.

## Test plan
- **MUL 7 × −3:** operand_a = 7, operand_b = 0xFFFFFFFD, op = 0 → done after 33 cycles, z_high = 0xFFFFFFFF, z_low = 0xFFFFFFEB, busy high for exactly 34 cycles.
- **MUL extreme:** 0x80000000 × 0x80000000 → z_high = 0x40000000, z_low = 0x00000000.
- **DIV −7 / 2:** → z_low = 0xFFFFFFFD (−3), z_high = 0xFFFFFFFF (−1); then 7 / −2 → z_low = 0xFFFFFFFD, z_high = 0x00000001.
- **DIV by zero:** 5 / 0 → done one cycle after start, z_low = 0xFFFFFFFF, z_high = 5, div_by_zero = 1. A following 6 × 2 clears the flag and gives z_low = 12.
- **start during RUN, then reset:**
  - Pulse start with different operands at cycle 10 of a MUL → ignored; the original result is delivered.
  - Then assert clear_n low at cycle 15 of a new DIV → all outputs 0 immediately, no done pulse.
  - A subsequent 100 / 7 → z_low = 14, z_high = 2.
